nms_frame_sequencer: RTL and testbench

//  Frame-level controller for the NMS stage. It sits between the FAST score stage and NMS, and

---
 rtl/nms_frame_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_nms_frame_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nms_frame_sequencer.sv
// Frame sequencer in front of the NMS stage: primes a zero row, streams the frame with zero
// substitution on source underrun, flushes the NMS pipeline and tags each decision with (x,y).
module nms_frame_sequencer #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int NMS_LAT = 644
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [7:0]                 s_score,
   input  logic                       s_flag,
   input  logic [9:0]                 s_depth,
   output logic                       nms_valid,
   output logic [7:0]                 nms_score,
   output logic                       nms_flag,
   output logic [9:0]                 nms_depth,
   input  logic [7:0]                 nms_o_score,
   input  logic                       nms_o_flag,
   input  logic [9:0]                 nms_o_depth,
   output logic                       m_valid,
   output logic                       m_flag,
   output logic [7:0]                 m_score,
   output logic [9:0]                 m_depth,
   output logic [$clog2(WIDTH)-1:0]   m_x,
   output logic [$clog2(HEIGHT)-1:0]  m_y,
   output logic                       m_last,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_underrun,
   output logic [15:0]                o_kp_count
);

   localparam int NPIX = WIDTH * HEIGHT;
   localparam int CNTW = $clog2(NPIX + NMS_LAT + 1);
   localparam int XW   = $clog2(WIDTH);
   localparam int YW   = $clog2(HEIGHT);

   localparam logic [CNTW-1:0] PRIME_LAST = CNTW'(WIDTH - 1);
   localparam logic [CNTW-1:0] RUN_LAST   = CNTW'(NPIX - 1);
   localparam logic [CNTW-1:0] FLUSH_LAST = CNTW'(NPIX + NMS_LAT - 1);
   localparam logic [CNTW-1:0] CAP_FIRST  = CNTW'(NMS_LAT - 1);
   localparam logic [CNTW-1:0] CAP_LAST   = CNTW'(NPIX + NMS_LAT - 2);
   localparam logic [XW-1:0]   X_LAST     = XW'(WIDTH - 1);
   localparam logic [YW-1:0]   Y_LAST     = YW'(HEIGHT - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      RUN,
      FLUSH,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic              underrun_q, underrun_d;
   logic [15:0]       kpCount_q, kpCount_d;
   logic              passPix;
   logic              capture;

   logic              mValid_q, mFlag_q, mLast_q;
   logic [7:0]        mScore_q;
   logic [9:0]        mDepth_q;
   logic [XW-1:0]     mX_q;
   logic [YW-1:0]     mY_q;

   assign s_ready   = (state_q == RUN);
   assign nms_valid = (state_q == PRIME) || (state_q == RUN) || (state_q == FLUSH);
   assign passPix   = s_ready && s_valid;
   assign nms_score = passPix ? s_score : 8'd0;
   assign nms_flag  = passPix && s_flag;
   assign nms_depth = passPix ? s_depth : 10'd0;

   // cnt_q runs on from RUN into FLUSH, so decision k sits on the NMS outputs at cnt_q == k+NMS_LAT-1.
   assign capture = ((state_q == RUN) || (state_q == FLUSH)) &&
                    (cnt_q >= CAP_FIRST) && (cnt_q <= CAP_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      underrun_d = underrun_q;
      kpCount_d  = kpCount_q;
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d    = PRIME;
               cnt_d      = '0;
               x_d        = '0;
               y_d        = '0;
               underrun_d = 1'b0;
               kpCount_d  = 16'd0;
            end
         end
         PRIME: begin
            if (cnt_q == PRIME_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (!s_valid) begin
               underrun_d = 1'b1;
            end
            if (cnt_q == RUN_LAST) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (capture) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
         if (nms_o_flag && (kpCount_q != 16'hFFFF)) begin
            kpCount_d = kpCount_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         underrun_q <= 1'b0;
         kpCount_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         underrun_q <= underrun_d;
         kpCount_q  <= kpCount_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mValid_q <= 1'b0;
         mFlag_q  <= 1'b0;
         mScore_q <= 8'd0;
         mDepth_q <= 10'd0;
         mX_q     <= '0;
         mY_q     <= '0;
         mLast_q  <= 1'b0;
      end else begin
         mValid_q <= capture;
         mFlag_q  <= capture && nms_o_flag;
         mScore_q <= (capture && nms_o_flag) ? nms_o_score : 8'd0;
         mDepth_q <= (capture && nms_o_flag) ? nms_o_depth : 10'd0;
         mX_q     <= capture ? x_q : '0;
         mY_q     <= capture ? y_q : '0;
         mLast_q  <= capture && (x_q == X_LAST) && (y_q == Y_LAST);
      end
   end

   assign m_valid    = mValid_q;
   assign m_flag     = mFlag_q;
   assign m_score    = mScore_q;
   assign m_depth    = mDepth_q;
   assign m_x        = mX_q;
   assign m_y        = mY_q;
   assign m_last     = mLast_q;
   assign o_busy     = (state_q != IDLE);
   assign o_done     = (state_q == DONE);
   assign o_underrun = underrun_q;
   assign o_kp_count = kpCount_q;

endmodule

// File: tb/tb_nms_frame_sequencer.sv
// Bench for nms_frame_sequencer on a 4x3 frame, with a streaming 3x3 NMS environment model
// driving nms_o_* and a frame-array golden model for the random frames.
module tb_nms_frame_sequencer;

   localparam int W           = 4;
   localparam int H           = 3;
   localparam int L           = 8;
   localparam int N           = W * H;
   localparam int XW          = $clog2(W);
   localparam int YW          = $clog2(H);
   localparam int VW          = 1 + 8 + 10 + XW + YW + 1;
   localparam int HIST        = 4096;
   localparam int FRAME_BEATS = W + N + L;

   logic              i_clk       = 1'b0;
   logic              i_rst_n     = 1'b0;
   logic              i_start     = 1'b0;
   logic              s_valid     = 1'b0;
   logic              s_ready;
   logic [7:0]        s_score     = 8'd0;
   logic              s_flag      = 1'b0;
   logic [9:0]        s_depth     = 10'd0;
   logic              nms_valid;
   logic [7:0]        nms_score;
   logic              nms_flag;
   logic [9:0]        nms_depth;
   logic [7:0]        nms_o_score = 8'd0;
   logic              nms_o_flag  = 1'b0;
   logic [9:0]        nms_o_depth = 10'd0;
   logic              m_valid, m_flag, m_last;
   logic [7:0]        m_score;
   logic [9:0]        m_depth;
   logic [XW-1:0]     m_x;
   logic [YW-1:0]     m_y;
   logic              o_busy, o_done, o_underrun;
   logic [15:0]       o_kp_count;

   int checks = 0;
   int errors = 0;

   logic              frmFlag [N];
   logic [7:0]        frmScore[N];
   logic [9:0]        frmDepth[N];

   logic [VW-1:0]     capVec[N];
   int                mvCnt, doneCnt, busyCnt, mvAfterDone, idleMv;
   int                frameId = 0;
   int                seenFrame = 0;

   logic              hFlag [HIST];
   logic [7:0]        hScore[HIST];
   logic [9:0]        hDepth[HIST];
   int                cyc = 0;
   int                mp;
   bit                mKept;

   nms_frame_sequencer #(
      .WIDTH   (W),
      .HEIGHT  (H),
      .NMS_LAT (L)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_score     (s_score),
      .s_flag      (s_flag),
      .s_depth     (s_depth),
      .nms_valid   (nms_valid),
      .nms_score   (nms_score),
      .nms_flag    (nms_flag),
      .nms_depth   (nms_depth),
      .nms_o_score (nms_o_score),
      .nms_o_flag  (nms_o_flag),
      .nms_o_depth (nms_o_depth),
      .m_valid     (m_valid),
      .m_flag      (m_flag),
      .m_score     (m_score),
      .m_depth     (m_depth),
      .m_x         (m_x),
      .m_y         (m_y),
      .m_last      (m_last),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_underrun  (o_underrun),
      .o_kp_count  (o_kp_count)
   );

   always #5 i_clk = ~i_clk;

   // NMS stand-in: free-running stream, decision for the beat entered L-1 cycles ago, neighbours
   // taken by raster position; o_score/o_depth are raw so the sequencer must zero them itself.
   always @(negedge i_clk) begin
      if (frameId != seenFrame) begin
         seenFrame   = frameId;
         mvCnt       = 0;
         doneCnt     = 0;
         busyCnt     = 0;
         mvAfterDone = 0;
         idleMv      = 0;
      end
      if (cyc < HIST) begin
         hFlag[cyc]  = nms_flag;
         hScore[cyc] = nms_score;
         hDepth[cyc] = nms_depth;
      end
      mp    = cyc - (L - 1);
      mKept = 1'b0;
      if (mp >= W + 1 && cyc < HIST) begin
         mKept = hFlag[mp];
         for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
               if ((dy != 0 || dx != 0) && hFlag[mp + dy * W + dx] &&
                   hScore[mp + dy * W + dx] >= hScore[mp]) begin
                  mKept = 1'b0;
               end
            end
         end
         nms_o_score = hScore[mp];
         nms_o_depth = hDepth[mp];
      end
      nms_o_flag = mKept;
      if (m_valid) begin
         if (mvCnt < N) begin
            capVec[mvCnt] = {m_flag, m_score, m_depth, m_x, m_y, m_last};
         end
         mvCnt++;
         if (doneCnt > 0) mvAfterDone++;
         if (!o_busy) idleMv++;
      end
      if (o_busy && !o_done) busyCnt++;
      if (o_done) doneCnt++;
      cyc++;
   end

   function automatic bit golden_keep(input int x, input int y);
      bit keep;
      int nx, ny;
      keep = frmFlag[y * W + x];
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            nx = x + dx;
            ny = y + dy;
            if ((dy != 0 || dx != 0) && nx >= 0 && nx < W && ny >= 0 && ny < H) begin
               if (frmFlag[ny * W + nx] && frmScore[ny * W + nx] >= frmScore[y * W + x]) keep = 1'b0;
            end
         end
      end
      return keep;
   endfunction

   task automatic clear_frame();
      for (int k = 0; k < N; k++) begin
         frmFlag[k]  = 1'b0;
         frmScore[k] = 8'(k * 37 + 11);
         frmDepth[k] = 10'(k * 29 + 3);
      end
   endtask

   task automatic single_kp_frame();
      clear_frame();
      frmFlag[5]  = 1'b1;
      frmScore[5] = 8'd50;
      frmDepth[5] = 10'd321;
   endtask

   task automatic run_frame(input int dropBeat, input int startBeat, input int rstAfter);
      int k, guard;
      frameId++;
      for (int i = 0; i < N; i++) capVec[i] = '1;
      @(posedge i_clk); #1 i_start = 1'b1;
      @(posedge i_clk); #1 i_start = 1'b0;
      k = 0;
      guard = 0;
      while (k < N && guard < 4 * FRAME_BEATS) begin
         if (s_ready) begin
            s_valid = (k != dropBeat);
            s_score = frmScore[k];
            s_flag  = frmFlag[k];
            s_depth = frmDepth[k];
            i_start = (k == startBeat);
            k++;
         end
         @(posedge i_clk); #1;
         i_start = 1'b0;
         s_valid = 1'b0;
         s_score = 8'd0;
         s_flag  = 1'b0;
         s_depth = 10'd0;
         guard++;
      end
      if (rstAfter >= 0) begin
         repeat (rstAfter) @(posedge i_clk);
         #1 i_rst_n = 1'b0;
         #2;
         return;
      end
      guard = 0;
      while (doneCnt == 0 && guard < 4 * FRAME_BEATS) begin
         @(posedge i_clk);
         guard++;
      end
      repeat (3) @(posedge i_clk);
      #1;
      checks++;
      if (doneCnt == 0) begin
         errors++;
         $display("[TB] FAIL frame_timeout: o_done count %0d, required 1", doneCnt);
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if ({o_busy, o_done, s_ready, nms_valid, m_valid, m_flag, m_last, o_underrun} !== 8'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b, required 00000000",
                  {o_busy, o_done, s_ready, nms_valid, m_valid, m_flag, m_last, o_underrun});
      end
      checks++;
      if (o_kp_count !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_kp: got %0d, required 0", o_kp_count);
      end
      checks++;
      if ({m_score, m_depth, m_x, m_y} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_m_data: got %h, required 0", {m_score, m_depth, m_x, m_y});
      end
      @(negedge i_clk) i_rst_n = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_no_start: o_busy %b, required 0", o_busy);
      end
   endtask

   task automatic test_single_kp();
      logic [VW-1:0] exp;
      single_kp_frame();
      run_frame(-1, -1, -1);
      checks++;
      if (mvCnt !== N) begin
         errors++;
         $display("[TB] FAIL single_mv_count: got %0d, required %0d", mvCnt, N);
      end
      for (int k = 0; k < N; k++) begin
         exp = {(k == 5), (k == 5) ? 8'd50 : 8'd0, (k == 5) ? 10'd321 : 10'd0,
                XW'(k % W), YW'(k / W), (k == N - 1)};
         checks++;
         if (capVec[k] !== exp) begin
            errors++;
            $display("[TB] FAIL single_pix[%0d]: got %h, required %h", k, capVec[k], exp);
         end
      end
      checks++;
      if (o_kp_count !== 16'd1 || o_underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_kp_under: kp %0d underrun %b, required 1 and 0", o_kp_count, o_underrun);
      end
      checks++;
      if (busyCnt !== FRAME_BEATS || doneCnt !== 1) begin
         errors++;
         $display("[TB] FAIL single_timing: busy %0d done %0d, required %0d and 1", busyCnt, doneCnt, FRAME_BEATS);
      end
      checks++;
      if (mvAfterDone !== 0 || idleMv !== 0) begin
         errors++;
         $display("[TB] FAIL single_mv_window: after_done %0d idle %0d, required 0 and 0", mvAfterDone, idleMv);
      end
   endtask

   task automatic test_adjacent();
      logic [VW-1:0] exp;
      clear_frame();
      frmFlag[5]  = 1'b1;
      frmScore[5] = 8'd50;
      frmDepth[5] = 10'd321;
      frmFlag[6]  = 1'b1;
      frmScore[6] = 8'd60;
      frmDepth[6] = 10'd456;
      run_frame(-1, -1, -1);
      for (int k = 4; k < 8; k++) begin
         exp = {(k == 6), (k == 6) ? 8'd60 : 8'd0, (k == 6) ? 10'd456 : 10'd0,
                XW'(k % W), YW'(k / W), 1'b0};
         checks++;
         if (capVec[k] !== exp) begin
            errors++;
            $display("[TB] FAIL adjacent_pix[%0d]: got %h, required %h", k, capVec[k], exp);
         end
      end
      checks++;
      if (o_kp_count !== 16'd1) begin
         errors++;
         $display("[TB] FAIL adjacent_kp: got %0d, required 1", o_kp_count);
      end
   endtask

   task automatic test_underrun();
      single_kp_frame();
      run_frame(5, -1, -1);
      checks++;
      if (o_underrun !== 1'b1 || o_kp_count !== 16'd0) begin
         errors++;
         $display("[TB] FAIL underrun_flags: underrun %b kp %0d, required 1 and 0", o_underrun, o_kp_count);
      end
      checks++;
      if (capVec[5] !== {1'b0, 8'd0, 10'd0, XW'(1), YW'(1), 1'b0}) begin
         errors++;
         $display("[TB] FAIL underrun_pix5: got %h, required %h", capVec[5],
                  {1'b0, 8'd0, 10'd0, XW'(1), YW'(1), 1'b0});
      end
      checks++;
      if (busyCnt !== FRAME_BEATS || mvCnt !== N) begin
         errors++;
         $display("[TB] FAIL underrun_timing: busy %0d mv %0d, required %0d and %0d", busyCnt, mvCnt, FRAME_BEATS, N);
      end
      run_frame(-1, -1, -1);
      checks++;
      if (o_underrun !== 1'b0 || o_kp_count !== 16'd1) begin
         errors++;
         $display("[TB] FAIL underrun_cleared: underrun %b kp %0d, required 0 and 1", o_underrun, o_kp_count);
      end
   endtask

   task automatic test_start_during_run();
      single_kp_frame();
      run_frame(-1, 3, -1);
      checks++;
      if (doneCnt !== 1 || busyCnt !== FRAME_BEATS) begin
         errors++;
         $display("[TB] FAIL restart_ignored: done %0d busy %0d, required 1 and %0d", doneCnt, busyCnt, FRAME_BEATS);
      end
      checks++;
      if (o_busy !== 1'b0 || mvCnt !== N || o_kp_count !== 16'd1) begin
         errors++;
         $display("[TB] FAIL restart_after: busy %b mv %0d kp %0d, required 0, %0d, 1", o_busy, mvCnt, o_kp_count, N);
      end
   endtask

   task automatic test_reset_in_flush();
      logic [VW-1:0] exp;
      single_kp_frame();
      run_frame(-1, -1, 3);
      checks++;
      if ({o_busy, o_done, s_ready, nms_valid, m_valid, m_flag, m_last} !== 7'b0 || o_kp_count !== 16'd0) begin
         errors++;
         $display("[TB] FAIL flush_reset: ctrl %b kp %0d, required 0000000 and 0",
                  {o_busy, o_done, s_ready, nms_valid, m_valid, m_flag, m_last}, o_kp_count);
      end
      checks++;
      if (doneCnt !== 0) begin
         errors++;
         $display("[TB] FAIL flush_reset_done: o_done count %0d, required 0", doneCnt);
      end
      @(negedge i_clk) i_rst_n = 1'b1;
      run_frame(-1, -1, -1);
      for (int k = 0; k < N; k++) begin
         exp = {(k == 5), (k == 5) ? 8'd50 : 8'd0, (k == 5) ? 10'd321 : 10'd0,
                XW'(k % W), YW'(k / W), (k == N - 1)};
         checks++;
         if (capVec[k] !== exp) begin
            errors++;
            $display("[TB] FAIL rerun_pix[%0d]: got %h, required %h", k, capVec[k], exp);
         end
      end
      checks++;
      if (o_kp_count !== 16'd1 || doneCnt !== 1) begin
         errors++;
         $display("[TB] FAIL rerun_kp: kp %0d done %0d, required 1 and 1", o_kp_count, doneCnt);
      end
   endtask

   task automatic test_random();
      logic [VW-1:0] exp;
      bit keep;
      int expKp;
      for (int f = 0; f < 3; f++) begin
         expKp = 0;
         for (int k = 0; k < N; k++) begin
            frmFlag[k]  = (k % W == 1 || k % W == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            frmScore[k] = 8'($urandom_range(0, 255));
            frmDepth[k] = 10'($urandom_range(0, 1023));
         end
         run_frame(-1, -1, -1);
         for (int k = 0; k < N; k++) begin
            keep = golden_keep(k % W, k / W);
            if (keep) expKp++;
            exp = {keep, keep ? frmScore[k] : 8'd0, keep ? frmDepth[k] : 10'd0,
                   XW'(k % W), YW'(k / W), (k == N - 1)};
            checks++;
            if (capVec[k] !== exp) begin
               errors++;
               $display("[TB] FAIL random%0d_pix[%0d]: got %h, required %h", f, k, capVec[k], exp);
            end
         end
         checks++;
         if (o_kp_count !== 16'(expKp)) begin
            errors++;
            $display("[TB] FAIL random%0d_kp: got %0d, required %0d", f, o_kp_count, expKp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_kp();
      test_adjacent();
      test_underrun();
      test_start_during_run();
      test_reset_in_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
